// File: rtl/reg_file_rw_if.sv
// rtl/reg_file_rw_if.sv - read/write/clear bus bundle for the register file
interface reg_file_rw_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              clr_req;
   logic              busy;
   logic              clr_done;

   modport slave (
      input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
      output rd_data_a, rd_data_b, busy, clr_done
   );

   modport master (
      output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
      input  rd_data_a, rd_data_b, busy, clr_done
   );
endinterface

// File: rtl/reg_file_rw.sv
// rtl/reg_file_rw.sv - 8x8 register file, two bypassed read ports, sequenced bulk clear
module reg_file_rw #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input logic           clk,
   input logic           rst_n,
   reg_file_rw_if.slave  bus
);
   localparam int NREGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         regs_q  <= regs_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      regs_d  = regs_q;
      case (state_q)
         S_IDLE: begin
            // A write coinciding with the clear request still commits.
            if (bus.wr_en) regs_d[bus.wr_addr] = bus.wr_data;
            if (bus.clr_req) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            regs_d[cnt_q] = '0;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic byp_ok;
   assign byp_ok = rst_n && (state_q == S_IDLE) && bus.wr_en;

   assign bus.rd_data_a = (byp_ok && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data
                                                                    : regs_q[bus.rd_addr_a];
   assign bus.rd_data_b = (byp_ok && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data
                                                                    : regs_q[bus.rd_addr_b];
   assign bus.busy      = (state_q == S_CLEAR);
   assign bus.clr_done  = done_q;
endmodule

// File: tb/tb_reg_file_rw.sv
// tb/tb_reg_file_rw.sv - directed self-checking bench for reg_file_rw
module tb_reg_file_rw;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   reg_file_rw_if bus ();

   reg_file_rw dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.clr_req   = 1'b0;
      bus.rd_addr_a = '0;
      bus.rd_addr_b = '0;
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      logic [2:0] a;
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         a = 3'(i);
         bus.rd_addr_a = a;
         bus.rd_addr_b = 3'(7 - i);
         #1;
         n_cmp++;
         if (bus.rd_data_a !== 8'h00 || bus.rd_data_b !== 8'h00) begin
            n_err++;
            $display("FAIL reset_read addr %0d: got a=%h b=%h want 00/00", i, bus.rd_data_a, bus.rd_data_b);
         end
      end
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.clr_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags: got busy=%b done=%b want 0/0", bus.busy, bus.clr_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write_readback();
      write_reg(3'd3, 8'hA5);
      bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 8'h3C;
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.rd_addr_a = 3'd3;
      bus.rd_addr_b = 3'd7;
      #1;
      n_cmp++;
      if (bus.rd_data_a !== 8'hA5 || bus.rd_data_b !== 8'h3C) begin
         n_err++;
         $display("FAIL write_readback: got a=%h b=%h want a5/3c", bus.rd_data_a, bus.rd_data_b);
      end
   endtask

   task automatic test_bypass();
      write_reg(3'd2, 8'h11);
      bus.rd_addr_a = 3'd2;
      bus.rd_addr_b = 3'd2;
      #1;
      n_cmp++;
      if (bus.rd_data_a !== 8'h11) begin
         n_err++;
         $display("FAIL bypass_pre: got %h want 11", bus.rd_data_a);
      end
      bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'h99;
      #1;
      n_cmp++;
      if (bus.rd_data_a !== 8'h99 || bus.rd_data_b !== 8'h99) begin
         n_err++;
         $display("FAIL bypass_same_cycle: got a=%h b=%h want 99/99", bus.rd_data_a, bus.rd_data_b);
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      #1;
      n_cmp++;
      if (bus.rd_data_a !== 8'h99 || bus.rd_data_b !== 8'h99) begin
         n_err++;
         $display("FAIL bypass_stored: got a=%h b=%h want 99/99", bus.rd_data_a, bus.rd_data_b);
      end
   endtask

   task automatic test_clear();
      logic       exp_busy, exp_done;
      logic [7:0] exp5, exp0;
      int         pulses;
      for (int i = 0; i < 8; i++) write_reg(3'(i), 8'(8'h10 + i));
      bus.clr_req   = 1'b1;
      bus.rd_addr_a = 3'd5;
      bus.rd_addr_b = 3'd0;
      pulses = 0;
      @(negedge clk);
      bus.clr_req = 1'b0;
      // m counts negedges after the sampling edge k
      for (int m = 0; m < 10; m++) begin
         bus.wr_en   = (m == 2);
         bus.wr_addr = 3'd0;
         bus.wr_data = 8'hFF;
         #1;
         exp_busy = (m <= 7);
         exp_done = (m == 8);
         exp5     = (m >= 6) ? 8'h00 : 8'h15;
         exp0     = (m >= 1) ? 8'h00 : 8'h10;
         if (bus.clr_done === 1'b1) pulses++;
         n_cmp++;
         if (bus.busy !== exp_busy || bus.clr_done !== exp_done) begin
            n_err++;
            $display("FAIL clear_flags m=%0d: got busy=%b done=%b want %b/%b", m, bus.busy, bus.clr_done, exp_busy, exp_done);
         end
         n_cmp++;
         if (bus.rd_data_a !== exp5 || bus.rd_data_b !== exp0) begin
            n_err++;
            $display("FAIL clear_data m=%0d: got r5=%h r0=%h want %h/%h", m, bus.rd_data_a, bus.rd_data_b, exp5, exp0);
         end
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      n_cmp++;
      if (pulses != 1) begin
         n_err++;
         $display("FAIL clear_done_count: got %0d want 1", pulses);
      end
      for (int i = 0; i < 8; i++) begin
         bus.rd_addr_a = 3'(i);
         #1;
         n_cmp++;
         if (bus.rd_data_a !== 8'h00) begin
            n_err++;
            $display("FAIL clear_final reg%0d: got %h want 00", i, bus.rd_data_a);
         end
      end
   endtask

   task automatic test_simultaneous();
      int guard;
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'h77;
      bus.clr_req = 1'b1;
      bus.rd_addr_a = 3'd0;
      #1;
      n_cmp++;
      if (bus.rd_data_a !== 8'h77) begin
         n_err++;
         $display("FAIL simul_bypass: got %h want 77", bus.rd_data_a);
      end
      @(negedge clk);
      bus.wr_en = 1'b0; bus.clr_req = 1'b0;
      #1;
      n_cmp++;
      if (bus.rd_data_a !== 8'h77 || bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL simul_committed: got %h busy=%b want 77/1", bus.rd_data_a, bus.busy);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.rd_data_a !== 8'h00) begin
         n_err++;
         $display("FAIL simul_cleared: got %h want 00", bus.rd_data_a);
      end
      guard = 0;
      while (bus.busy === 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL simul_timeout: busy=%b want 0", bus.busy);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int guard;
      @(negedge clk);
      bus.clr_req = 1'b1;
      @(negedge clk);
      repeat (8) @(negedge clk);
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.clr_done !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_end: got busy=%b done=%b want 0/1", bus.busy, bus.clr_done);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.clr_done !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_restart: got busy=%b done=%b want 1/0", bus.busy, bus.clr_done);
      end
      bus.clr_req = 1'b0;
      guard = 0;
      while (bus.busy === 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_timeout: busy=%b want 0", bus.busy);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_clear();
      int pulses;
      write_reg(3'd4, 8'h44);
      write_reg(3'd6, 8'h66);
      bus.clr_req = 1'b1;
      @(negedge clk);
      bus.clr_req = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL midclr_busy_before: got %b want 1", bus.busy);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.clr_done !== 1'b0) begin
         n_err++;
         $display("FAIL midclr_abort: got busy=%b done=%b want 0/0", bus.busy, bus.clr_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         bus.rd_addr_a = 3'(i % 8);
         #1;
         if (bus.clr_done === 1'b1) pulses++;
         n_cmp++;
         if (bus.rd_data_a !== 8'h00 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL midclr_after reg%0d: got %h busy=%b want 00/0", i % 8, bus.rd_data_a, bus.busy);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (pulses != 0) begin
         n_err++;
         $display("FAIL midclr_no_done: got %0d pulses want 0", pulses);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_write_readback();
      test_bypass();
      test_clear();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
